// File: rtl/trig_monitor_pkg.sv
// Shared types and defaults for the trigger monitor.
// Timestamp capture is built only when TRIG_MONITOR_TS_EN is defined.
package trig_monitor_pkg;

   localparam int unsigned CntWDefault     = 16;
   localparam int unsigned TsWDefault      = 32;
   localparam int unsigned DebounceDefault = 2;
   localparam int unsigned DebounceMin     = 1;
   localparam int unsigned DebounceMax     = 15;
   localparam int unsigned QualW           = 4;

   typedef enum logic [1:0] {
      StIdle,
      StQual,
      StActive
   } state_e;

endpackage

// File: rtl/trig_sync.sv
// Two-flop synchronizer for the asynchronous trigger level.
module trig_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/trig_monitor.sv
// Debounced trigger monitor: counts qualified activations, raises a sticky alarm and,
// with TRIG_MONITOR_TS_EN defined, captures the timestamp of the first activation.
module trig_monitor
   import trig_monitor_pkg::*;
#(
   parameter int unsigned CNT_W    = CntWDefault,
   parameter int unsigned TS_W     = TsWDefault,
   parameter int unsigned DEBOUNCE = DebounceDefault
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trigger_in,
   input  logic             clr_req,
   output logic             clr_ack,
   output logic             alarm,
   output logic [CNT_W-1:0] act_count,
   output logic [TS_W-1:0]  first_ts,
   output logic             ts_valid
);

   // Out-of-range DEBOUNCE values are clamped into the legal window.
   localparam int unsigned DebLim = (DEBOUNCE < DebounceMin) ? DebounceMin :
                                    (DEBOUNCE > DebounceMax) ? DebounceMax : DEBOUNCE;
   localparam logic [QualW-1:0] QualTarget = QualW'(DebLim);

   logic s;

   trig_sync u_trig_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (trigger_in),
      .q     (s)
   );

   state_e             state_q, state_d;
   logic [QualW-1:0]   qual_cnt_q, qual_cnt_d;
   logic               enter_act;

   always_comb begin
      state_d    = state_q;
      qual_cnt_d = qual_cnt_q;
      enter_act  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (s) begin
               if (DebLim == 1) begin
                  state_d    = StActive;
                  qual_cnt_d = '0;
                  enter_act  = 1'b1;
               end else begin
                  state_d    = StQual;
                  qual_cnt_d = QualW'(1);
               end
            end
         end
         StQual: begin
            if (!s) begin
               state_d    = StIdle;
               qual_cnt_d = '0;
            end else if (qual_cnt_q + QualW'(1) == QualTarget) begin
               state_d    = StActive;
               qual_cnt_d = '0;
               enter_act  = 1'b1;
            end else begin
               qual_cnt_d = qual_cnt_q + QualW'(1);
            end
         end
         StActive: begin
            if (!s) state_d = StIdle;
         end
         default: begin
            state_d    = StIdle;
            qual_cnt_d = '0;
         end
      endcase
   end

   logic             clr_prev_q, clr_prev_d;
   logic             clr_ack_q, clr_ack_d;
   logic             clr_rise;
   logic             alarm_q, alarm_d;
   logic [CNT_W-1:0] act_count_q, act_count_d;

   assign clr_rise = clr_req & ~clr_prev_q;

   // A clear wins over a coinciding activation; the FSM still advances.
   always_comb begin
      clr_prev_d  = clr_req;
      clr_ack_d   = clr_rise;
      alarm_d     = alarm_q;
      act_count_d = act_count_q;
      if (clr_rise) begin
         alarm_d     = 1'b0;
         act_count_d = '0;
      end else if (enter_act) begin
         alarm_d = 1'b1;
         if (act_count_q != '1) act_count_d = act_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         qual_cnt_q  <= '0;
         clr_prev_q  <= 1'b0;
         clr_ack_q   <= 1'b0;
         alarm_q     <= 1'b0;
         act_count_q <= '0;
      end else begin
         state_q     <= state_d;
         qual_cnt_q  <= qual_cnt_d;
         clr_prev_q  <= clr_prev_d;
         clr_ack_q   <= clr_ack_d;
         alarm_q     <= alarm_d;
         act_count_q <= act_count_d;
      end
   end

   assign clr_ack   = clr_ack_q;
   assign alarm     = alarm_q;
   assign act_count = act_count_q;

`ifdef TRIG_MONITOR_TS_EN
   logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
   logic [TS_W-1:0] first_ts_q, first_ts_d;
   logic            ts_valid_q, ts_valid_d;

   always_comb begin
      ts_cnt_d   = (ts_cnt_q == '1) ? ts_cnt_q : ts_cnt_q + TS_W'(1);
      first_ts_d = first_ts_q;
      ts_valid_d = ts_valid_q;
      if (clr_rise) begin
         first_ts_d = '0;
         ts_valid_d = 1'b0;
      end else if (enter_act && !ts_valid_q) begin
         first_ts_d = ts_cnt_q;
         ts_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_cnt_q   <= '0;
         first_ts_q <= '0;
         ts_valid_q <= 1'b0;
      end else begin
         ts_cnt_q   <= ts_cnt_d;
         first_ts_q <= first_ts_d;
         ts_valid_q <= ts_valid_d;
      end
   end

   assign first_ts = first_ts_q;
   assign ts_valid = ts_valid_q;
`else
   assign first_ts = '0;
   assign ts_valid = 1'b0;
`endif

endmodule

// File: tb/tb_trig_monitor.sv
// Randomized and directed bench for trig_monitor against an activation-level reference model.
module tb_trig_monitor;

`ifdef TRIG_MONITOR_TS_EN
   localparam bit TsEn = 1'b1;
`else
   localparam bit TsEn = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic trigger_in;
   logic clr_req;

   logic        clr_ack0, alarm0, ts_valid0;
   logic [15:0] act_count0;
   logic [31:0] first_ts0;
   logic        clr_ack1, alarm1, ts_valid1;
   logic [1:0]  act_count1;
   logic [31:0] first_ts1;

   trig_monitor dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .trigger_in (trigger_in),
      .clr_req    (clr_req),
      .clr_ack    (clr_ack0),
      .alarm      (alarm0),
      .act_count  (act_count0),
      .first_ts   (first_ts0),
      .ts_valid   (ts_valid0)
   );

   trig_monitor #(
      .CNT_W    (2),
      .TS_W     (32),
      .DEBOUNCE (3)
   ) dut_sat (
      .clk        (clk),
      .rst_n      (rst_n),
      .trigger_in (trigger_in),
      .clr_req    (clr_req),
      .clr_ack    (clr_ack1),
      .alarm      (alarm1),
      .act_count  (act_count1),
      .first_ts   (first_ts1),
      .ts_valid   (ts_valid1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: an activation is the DEBOUNCE-th consecutive high sample of the
   // trigger as seen two edges late; counts saturate at the instance's maximum.
   int     db [2]  = '{2, 3};
   longint cap [2] = '{65535, 3};
   bit     hist [$];
   int     run [2];
   longint cnt [2];
   bit     m_alarm [2];
   bit     m_tsv [2];
   longint m_first [2];
   bit     m_ack;
   bit     clr_prev;
   longint m_ts;
   int     ecnt;

   task automatic model_reset();
      hist = '{1'b0, 1'b0};
      for (int i = 0; i < 2; i++) begin
         run[i] = 0; cnt[i] = 0; m_alarm[i] = 0; m_tsv[i] = 0; m_first[i] = 0;
      end
      m_ack = 0; clr_prev = 0; m_ts = 0; ecnt = 0;
   endtask

   task automatic model_edge(input bit trg, input bit clr);
      bit s;
      bit rise;
      s = hist[1];
      hist.push_front(trg);
      void'(hist.pop_back());
      rise = clr && !clr_prev;
      clr_prev = clr;
      m_ack = rise;
      for (int i = 0; i < 2; i++) begin
         run[i] = s ? run[i] + 1 : 0;
         if (rise) begin
            cnt[i] = 0; m_alarm[i] = 0; m_tsv[i] = 0; m_first[i] = 0;
         end else if (run[i] == db[i]) begin
            if (cnt[i] < cap[i]) cnt[i]++;
            m_alarm[i] = 1;
            if (!m_tsv[i]) begin
               m_first[i] = m_ts;
               m_tsv[i] = 1;
            end
         end
      end
      m_ts++;
      ecnt++;
   endtask

   task automatic compare_all();
      check_eq("ack0",   32'(clr_ack0),   32'(m_ack));
      check_eq("alarm0", 32'(alarm0),     32'(m_alarm[0]));
      check_eq("cnt0",   32'(act_count0), 32'(cnt[0]));
      check_eq("fts0",   first_ts0,       TsEn ? 32'(m_first[0]) : 32'd0);
      check_eq("tsv0",   32'(ts_valid0),  TsEn ? 32'(m_tsv[0]) : 32'd0);
      check_eq("ack1",   32'(clr_ack1),   32'(m_ack));
      check_eq("alarm1", 32'(alarm1),     32'(m_alarm[1]));
      check_eq("cnt1",   32'(act_count1), 32'(cnt[1]));
      check_eq("fts1",   first_ts1,       TsEn ? 32'(m_first[1]) : 32'd0);
      check_eq("tsv1",   32'(ts_valid1),  TsEn ? 32'(m_tsv[1]) : 32'd0);
   endtask

   // Called just after a falling edge; drives inputs, takes one rising edge, checks.
   task automatic cycle(input bit trg, input bit clr);
      trigger_in = trg;
      clr_req    = clr;
      @(posedge clk);
      model_edge(trg, clr);
      #1;
      compare_all();
      @(negedge clk);
   endtask

   int  acks;
   bit  r_trg;
   bit  r_clr;
   int  run_left;

   initial begin
      rst_n = 1'b0;
      trigger_in = 1'b0;
      clr_req = 1'b0;
      model_reset();
      #2;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Qualified activation with trigger first sampled at edge 100.
      repeat (99) cycle(1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         cycle(1'b1, 1'b0);
         if (ecnt == 102) check_eq("lat_early", 32'(alarm0), 32'd0);
         if (ecnt == 103) begin
            check_eq("lat_alarm", 32'(alarm0), 32'd1);
            check_eq("lat_cnt", 32'(act_count0), 32'd1);
            check_eq("lat_fts", first_ts0, TsEn ? 32'd102 : 32'd0);
            check_eq("lat_tsv", 32'(ts_valid0), TsEn ? 32'd1 : 32'd0);
         end
      end
      check_eq("held_cnt", 32'(act_count0), 32'd1);
      repeat (4) cycle(1'b0, 1'b0);

      // Single-cycle pulse must not qualify.
      cycle(1'b1, 1'b0);
      repeat (5) cycle(1'b0, 1'b0);
      check_eq("pulse_cnt", 32'(act_count0), 32'd1);

      // Three separate activations, then two more to saturate the 2-bit instance.
      repeat (3) begin
         repeat (4) cycle(1'b1, 1'b0);
         repeat (4) cycle(1'b0, 1'b0);
      end
      check_eq("three_cnt", 32'(act_count0), 32'd4);
      check_eq("three_fts", first_ts0, TsEn ? 32'd102 : 32'd0);
      repeat (2) begin
         repeat (4) cycle(1'b1, 1'b0);
         repeat (4) cycle(1'b0, 1'b0);
      end
      check_eq("sat_cnt", 32'(act_count1), 32'd3);
      check_eq("six_cnt", 32'(act_count0), 32'd6);

      // Clear held for five cycles yields exactly one acknowledge.
      acks = 0;
      repeat (5) begin
         cycle(1'b0, 1'b1);
         acks += int'(clr_ack0);
      end
      cycle(1'b0, 1'b0);
      acks += int'(clr_ack0);
      check_eq("clr_acks", 32'(acks), 32'd1);
      check_eq("clr_cnt", 32'(act_count0), 32'd0);
      check_eq("clr_alarm", 32'(alarm0), 32'd0);
      check_eq("clr_tsv", 32'(ts_valid0), 32'd0);

      // Clear coinciding with the qualifying edge of the DEBOUNCE=2 instance.
      repeat (2) cycle(1'b0, 1'b0);
      repeat (3) cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b1);
      check_eq("coinc_cnt", 32'(act_count0), 32'd0);
      check_eq("coinc_alarm", 32'(alarm0), 32'd0);
      repeat (4) cycle(1'b1, 1'b1);
      check_eq("held_nocnt", 32'(act_count0), 32'd0);
      repeat (3) cycle(1'b0, 1'b0);
      repeat (4) cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      check_eq("recount", 32'(act_count0), 32'd1);

      // Reset asserted mid-qualification with the trigger held high.
      repeat (3) cycle(1'b0, 1'b0);
      repeat (3) cycle(1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #1;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         cycle(1'b1, 1'b0);
         if (k == 3) check_eq("rst_pre", 32'(act_count0), 32'd0);
         if (k == 4) check_eq("rst_act", 32'(act_count0), 32'd1);
      end

      // Randomized runs of trigger levels with occasional clear toggles.
      r_trg = 1'b0;
      r_clr = 1'b0;
      run_left = 0;
      repeat (2000) begin
         if (run_left == 0) begin
            r_trg = ~r_trg;
            run_left = int'($urandom_range(1, 7));
         end
         run_left--;
         if ($urandom_range(0, 15) == 0) r_clr = ~r_clr;
         cycle(r_trg, r_clr);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/trig_monitor.md
TRIG_MONITOR -- requirements
Module: trig_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the activation counter.
REQ-002 SHALL have parameter TS_W, default 32, width of the free-running timestamp and the captured timestamp.
REQ-003 SHALL have parameter DEBOUNCE, default 2, the number of consecutive synchronized-high samples that qualify an activation; legal range 1..15.
REQ-004 SHALL have the port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have the port trigger_in, input, 1 bit: trigger level from the trigger-condition logic, asynchronous to clk.
REQ-007 SHALL have the port clr_req, input, 1 bit: clear request, a level held until clr_ack.
REQ-008 SHALL have the port clr_ack, output, 1 bit: one-cycle clear acknowledge.
REQ-009 SHALL have the port alarm, output, 1 bit: sticky flag, set on the first qualified activation.
REQ-010 SHALL have the port act_count, output, CNT_W bits: number of qualified activations, saturating.
REQ-011 SHALL have the port first_ts, output, TS_W bits: timestamp of the first qualified activation.
REQ-012 SHALL have the port ts_valid, output, 1 bit: first_ts holds a captured value.

Function
REQ-013 SHALL pass trigger_in through a two-flop synchronizer; its output is s.
REQ-014 SHALL run the FSM IDLE, QUAL, ACTIVE.
- IDLE: s=1 enters QUAL, or ACTIVE directly when DEBOUNCE=1.
- QUAL: s=0 returns to IDLE and zeroes the qualification counter.
- QUAL: the DEBOUNCE-th consecutive s=1 sample enters ACTIVE.
- ACTIVE: s=0 returns to IDLE.
REQ-015 SHALL count exactly one activation on each entry to ACTIVE: act_count+1 saturating at all-ones, alarm set; a held trigger never recounts.
REQ-016 SHALL meet this latency: trigger_in first sampled high at edge N means alarm and act_count update after edge N+1+DEBOUNCE; DEBOUNCE=2 gives edge N+3.
REQ-017 SHALL run a free-running timestamp counter ts_cnt, zeroed at reset, incremented every cycle, saturating at all-ones.
REQ-018 SHALL, on the activation that finds ts_valid=0, load ts_cnt (pre-increment value) into first_ts and set ts_valid; later activations leave first_ts unchanged.
REQ-019 SHALL accept a clear only on a rising edge of the sampled clr_req: clr_ack=1 for exactly one cycle on the following edge; alarm, act_count, first_ts and ts_valid go to 0 on that same edge; ts_cnt is unaffected.
REQ-020 SHALL issue no further clr_ack while clr_req stays high; the next clear needs clr_req to go low and then high again.
REQ-021 SHALL let a clear win when it coincides with a qualifying edge: the activation is not counted, the state still enters ACTIVE, and no recount occurs until s falls.
REQ-022 SHALL keep the FSM state unchanged by a clear.

Reset
REQ-023 SHALL, while rst_n=0, hold the synchronizer flops, FSM (IDLE), qualification counter, ts_cnt, alarm, act_count, first_ts, ts_valid, clr_ack and the clr_req edge register at 0, asynchronously.
REQ-024 SHALL restart qualification from IDLE when reset is asserted mid-QUAL or mid-ACTIVE; if trigger_in is still high after release, it is a new activation.

Configuration
REQ-025 SHALL, with macro TRIG_MONITOR_TS_EN defined, implement ts_cnt, first_ts capture and ts_valid as specified.
REQ-026 SHALL, with TRIG_MONITOR_TS_EN undefined, omit ts_cnt and the capture registers, tie first_ts and ts_valid to 0, and keep all other behaviour identical.

Structure
REQ-027 SHALL place the FSM state enum, the default values of CNT_W, TS_W and DEBOUNCE, and the DEBOUNCE range constants in package trig_monitor_pkg.
REQ-028 SHALL implement the two-flop synchronizer as sub-module trig_sync, which has clk, rst_n, d and q.

Verification
REQ-029 SHALL cover a single-cycle trigger: trigger_in 1-cycle pulse, DEBOUNCE=2 -> alarm=0, act_count=0.
REQ-030 SHALL cover a qualified activation: trigger_in high at edge 100 (cycle 100), held 10 cycles -> alarm=1 and act_count=1 after edge 103, first_ts=102, ts_valid=1, no recount while held.
REQ-031 SHALL cover three separate activations: three qualified pulses -> act_count=3, first_ts unchanged from the first.
REQ-032 SHALL cover saturation: CNT_W=2, five qualified pulses -> act_count=3.
REQ-033 SHALL cover the clear handshake.
- clr_req raised and held 5 cycles -> exactly one clr_ack.
- All flags and counts go to 0.
- A clear coinciding with a qualifying edge -> act_count=0, and no count until trigger_in falls and rises again.
REQ-034 SHALL cover reset mid-QUAL: rst_n pulsed low mid-QUAL with trigger_in held high -> all outputs 0 during reset, then act_count=1 DEBOUNCE+2 edges after release.
